instr_fetch_unit: RTL and testbench

//   Consumer side of the ProgramCounter: accepts the fetch address it drives, issues one read to

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 50 +++++
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: fault codes, FSM states, NOP constant.
package instr_fetch_unit_pkg;

  localparam int unsigned FAULT_W = 2;

  localparam logic [FAULT_W-1:0] FETCH_OK       = 2'b00;
  localparam logic [FAULT_W-1:0] FETCH_MISALIGN = 2'b01;
  localparam logic [FAULT_W-1:0] FETCH_BUSERR   = 2'b10;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small circular buffer of fetched entries; head is read combinationally from storage.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 66
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_pop;
  logic             do_push;

  // Pop on empty is ignored; push on full only lands when a pop frees the slot.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (do_pop) rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: takes a PC, performs one instruction-memory read at a time and queues
// {pc, instr, fault} for decode. All state advances on the falling clock edge.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     FIFO_DEPTH  = 2,
  parameter logic [XLEN-1:0] FAULT_INSTR = XLEN'(RV_NOP)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic [1:0]      instr_fault
);

  localparam int unsigned EW = 2*XLEN + FAULT_W;
  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] addr_next;
  logic [CW-1:0]   resv;
  logic [CW-1:0]   resv_next;
  logic [CW-1:0]   count;
  logic            drop;
  logic            drop_next;
  logic            push;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head;
  logic            accept;

  // A new address is only taken when a slot beyond the in-flight reservations is free.
  assign pc_ready       = reset && (state == ST_IDLE) && !flush && !drop
                          && ((CW'(FIFO_DEPTH) - count) > resv);
  assign accept         = pc_ready && pc_valid;
  assign imem_req_valid = (state == ST_REQ);
  assign imem_req_addr  = addr;
  assign instr_valid    = (count != '0);
  assign {instr_pc, instr_data, instr_fault} = head;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (instr_ready),
    .clear (flush),
    .wdata (push_data),
    .rdata (head),
    .count (count)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      addr  <= '0;
      resv  <= '0;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
      resv  <= resv_next;
      drop  <= drop_next;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = addr;
    resv_next  = resv;
    drop_next  = drop;
    push       = 1'b0;
    push_data  = '0;

    if (drop && imem_rsp_valid) drop_next = 1'b0;

    if (flush) begin
      // A read already handed to memory (or handed over this edge) must have its reply swallowed.
      state_next = ST_IDLE;
      resv_next  = '0;
      if (((state == ST_WAIT) && !imem_rsp_valid) || ((state == ST_REQ) && imem_req_ready))
        drop_next = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (pc_in[1:0] != 2'b00) begin
              push      = 1'b1;
              push_data = {pc_in, FAULT_INSTR, FETCH_MISALIGN};
            end else begin
              addr_next  = pc_in;
              resv_next  = resv + CW'(1);
              state_next = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (imem_req_ready) state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            push       = 1'b1;
            push_data  = imem_rsp_err ? {addr, FAULT_INSTR, FETCH_BUSERR}
                                      : {addr, imem_rsp_data, FETCH_OK};
            resv_next  = resv - CW'(1);
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: bench-side memory, queue-based reference model,
// per-cycle comparison plus directed hand-computed checks.
module tb_instr_fetch_unit;

  localparam int DEPTH  = 2;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_WAIT = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [1:0]  f;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [1:0]  instr_fault;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;

  int          acc_cnt = 0;
  logic [31:0] acc_addr = '0;
  logic [31:0] dec_q[$];

  int          m_mode = M_IDLE;
  logic [31:0] m_addr = '0;
  bit          m_drop = 1'b0;
  ent_t        mq[$];

  instr_fetch_unit #(
    .XLEN        (32),
    .FIFO_DEPTH  (DEPTH),
    .FAULT_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return 32'hA500_0000 | a;
  endfunction

  // Address is accepted when the fetch stage is idle, not redirected, not waiting out a
  // dropped reply, and the decode queue has room.
  function automatic bit exp_pc_ready();
    return reset && (m_mode == M_IDLE) && !flush && !m_drop && (mq.size() < DEPTH);
  endfunction

  // Reference model: advances at every falling edge from the inputs in force.
  always begin
    @(negedge clk or negedge reset);
    if (!reset) begin
      m_mode = M_IDLE;
      m_drop = 1'b0;
      mq.delete();
    end else begin
      bit rdy;
      bit rsp;
      bit nd;
      rdy = exp_pc_ready();
      rsp = imem_rsp_valid;
      nd  = (m_drop && !rsp) || (m_mode == M_WAIT && !rsp) || (m_mode == M_REQ && imem_req_ready);
      if (flush) begin
        mq.delete();
        m_drop = nd;
        m_mode = M_IDLE;
      end else begin
        if (m_drop && rsp) m_drop = 1'b0;
        if (instr_ready && mq.size() > 0) mq.delete(0);
        case (m_mode)
          M_IDLE: if (pc_valid && rdy) begin
            if (pc_in[1:0] != 2'b00) mq.push_back('{pc_in, 32'h13, 2'b01});
            else begin
              m_addr = pc_in;
              m_mode = M_REQ;
            end
          end
          M_REQ: if (imem_req_ready) m_mode = M_WAIT;
          default: if (rsp) begin
            if (imem_rsp_err) mq.push_back('{m_addr, 32'h13, 2'b10});
            else              mq.push_back('{m_addr, imem_rsp_data, 2'b00});
            m_mode = M_IDLE;
          end
        endcase
      end
    end
  end

  // Bus observer: request handshakes and decode pops seen at each falling edge.
  always begin
    @(negedge clk);
    if (reset) begin
      if (imem_req_valid && imem_req_ready) begin
        acc_cnt  = acc_cnt + 1;
        acc_addr = imem_req_addr;
      end
      if (instr_valid && instr_ready) dec_q.push_back(instr_pc);
    end
  end

  // Instruction memory: single-cycle response pulse mem_lat edges after request acceptance.
  always begin
    int          seen;
    int          left;
    bit          pend;
    logic [31:0] paddr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = '0;
    if (!reset) begin
      pend = 1'b0;
      seen = acc_cnt;
    end else begin
      if (acc_cnt != seen) begin
        seen  = acc_cnt;
        pend  = 1'b1;
        left  = mem_lat;
        paddr = acc_addr;
      end
      if (pend) begin
        left = left - 1;
        if (left == 0) begin
          pend           = 1'b0;
          imem_rsp_valid = 1'b1;
          imem_rsp_err   = (paddr == 32'h200);
          imem_rsp_data  = mem_word(paddr);
        end
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk1("pc_ready", pc_ready, exp_pc_ready());
    chk1("req_valid", imem_req_valid, m_mode == M_REQ);
    if (m_mode == M_REQ) chk32("req_addr", imem_req_addr, m_addr);
    chk1("instr_valid", instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk32("instr_pc", instr_pc, mq[0].pc);
      chk32("instr_data", instr_data, mq[0].ins);
      chk32("instr_fault", 32'(instr_fault), 32'(mq[0].f));
    end else if (!reset) begin
      chk32("rst_instr_pc", instr_pc, 32'h0);
      chk32("rst_instr_data", instr_data, 32'h0);
      chk32("rst_instr_fault", 32'(instr_fault), 32'h0);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
      compare_model();
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    bit done;
    done     = 1'b0;
    pc_valid = 1'b1;
    pc_in    = a;
    for (int i = 0; i < 20; i++) begin
      #1;
      done = pc_ready;
      tick(1);
      if (done) break;
    end
    pc_valid = 1'b0;
    chk1($sformatf("fetch_accept_%h", a), done, 1'b1);
  endtask

  task automatic pop_one();
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int base_acc;
    int dbase;

    // Reset with a pending address: nothing moves.
    pc_valid = 1'b1;
    pc_in    = 32'h4;
    #1 reset = 1'b0;
    #1;
    chk1("t1_pc_ready", pc_ready, 1'b0);
    chk1("t1_req_valid", imem_req_valid, 1'b0);
    chk1("t1_instr_valid", instr_valid, 1'b0);
    chk32("t1_instr_pc", instr_pc, 32'h0);
    tick(3);
    chk1("t1_hold_pc_ready", pc_ready, 1'b0);
    chk1("t1_hold_req_valid", imem_req_valid, 1'b0);
    pc_valid = 1'b0;
    reset    = 1'b1;
    tick(1);

    // Aligned fetch, one-edge memory latency.
    base_acc = acc_cnt;
    fetch(32'h100);
    chk1("t2_req_valid", imem_req_valid, 1'b1);
    chk32("t2_req_addr", imem_req_addr, 32'h100);
    tick(2);
    chk1("t2_instr_valid", instr_valid, 1'b1);
    chk32("t2_instr_pc", instr_pc, 32'h100);
    chk32("t2_instr_data", instr_data, 32'h0050_0093);
    chk32("t2_instr_fault", 32'(instr_fault), 32'h0);
    chk32("t2_req_count", 32'(acc_cnt - base_acc), 32'd1);
    pop_one();
    chk1("t2_empty", instr_valid, 1'b0);

    // Misaligned: queued directly, no memory access.
    base_acc = acc_cnt;
    fetch(32'h102);
    chk1("t3_req_valid", imem_req_valid, 1'b0);
    chk1("t3_instr_valid", instr_valid, 1'b1);
    chk32("t3_instr_pc", instr_pc, 32'h102);
    chk32("t3_instr_data", instr_data, 32'h13);
    chk32("t3_instr_fault", 32'(instr_fault), 32'h1);
    chk32("t3_req_count", 32'(acc_cnt - base_acc), 32'd0);
    pop_one();

    // Bus error.
    fetch(32'h200);
    tick(2);
    chk32("t4_instr_pc", instr_pc, 32'h200);
    chk32("t4_instr_data", instr_data, 32'h13);
    chk32("t4_instr_fault", 32'(instr_fault), 32'h2);
    pop_one();

    // Backpressure: two entries fill the queue, third address waits for a pop.
    dbase = dec_q.size();
    fetch(32'h0);
    fetch(32'h4);
    pc_valid = 1'b1;
    pc_in    = 32'h8;
    tick(3);
    chk1("t5_full_ready", pc_ready, 1'b0);
    chk32("t5_head0", instr_pc, 32'h0);
    instr_ready = 1'b1;
    #1;
    chk1("t5_pop_ready", pc_ready, 1'b0);
    tick(1);
    instr_ready = 1'b0;
    #1;
    chk32("t5_head4", instr_pc, 32'h4);
    chk1("t5_ready_after_pop", pc_ready, 1'b1);
    tick(1);
    pc_valid = 1'b0;
    tick(2);
    instr_ready = 1'b1;
    tick(2);
    instr_ready = 1'b0;
    chk32("t5_dec_count", 32'(dec_q.size() - dbase), 32'd3);
    if (dec_q.size() >= dbase + 3) begin
      chk32("t5_order0", dec_q[dbase], 32'h0);
      chk32("t5_order1", dec_q[dbase+1], 32'h4);
      chk32("t5_order2", dec_q[dbase+2], 32'h8);
    end

    // Flush while the read is outstanding: its reply is swallowed.
    mem_lat     = 4;
    instr_ready = 1'b1;
    dbase       = dec_q.size();
    fetch(32'h300);
    tick(1);
    flush = 1'b1;
    #1;
    chk1("t6_flush_ready", pc_ready, 1'b0);
    tick(1);
    flush    = 1'b0;
    pc_valid = 1'b1;
    pc_in    = 32'h400;
    #1;
    chk1("t6_drop_ready", pc_ready, 1'b0);
    tick(1);
    chk1("t6_drop_ready2", pc_ready, 1'b0);
    tick(1);
    chk1("t6_drop_ready3", pc_ready, 1'b0);
    chk1("t6_no_entry", instr_valid, 1'b0);
    tick(1);
    chk1("t6_ready_after_drop", pc_ready, 1'b1);
    tick(1);
    pc_valid = 1'b0;
    mem_lat  = 1;
    tick(2);
    chk1("t6_instr_valid", instr_valid, 1'b1);
    chk32("t6_instr_pc", instr_pc, 32'h400);
    chk32("t6_instr_data", instr_data, 32'hA500_0400);
    tick(1);
    chk32("t6_dec_count", 32'(dec_q.size() - dbase), 32'd1);
    if (dec_q.size() > dbase) chk32("t6_dec_pc", dec_q[dbase], 32'h400);

    // Flush before memory accepts: request is withdrawn, no drop pending.
    imem_req_ready = 1'b0;
    base_acc       = acc_cnt;
    fetch(32'h600);
    tick(1);
    chk1("t7_req_held", imem_req_valid, 1'b1);
    chk32("t7_req_addr", imem_req_addr, 32'h600);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    #1;
    chk1("t7_withdrawn", imem_req_valid, 1'b0);
    chk1("t7_ready", pc_ready, 1'b1);
    chk32("t7_req_count", 32'(acc_cnt - base_acc), 32'd0);
    imem_req_ready = 1'b1;

    // Reset while waiting on memory clears everything at once.
    mem_lat = 4;
    fetch(32'h500);
    tick(1);
    reset = 1'b0;
    #1;
    chk1("t8_pc_ready", pc_ready, 1'b0);
    chk1("t8_req_valid", imem_req_valid, 1'b0);
    chk1("t8_instr_valid", instr_valid, 1'b0);
    chk32("t8_instr_pc", instr_pc, 32'h0);
    chk32("t8_instr_data", instr_data, 32'h0);
    chk32("t8_instr_fault", 32'(instr_fault), 32'h0);
    tick(2);
    reset   = 1'b1;
    mem_lat = 1;
    tick(6);
    chk1("t8_idle_ready", pc_ready, 1'b1);
    chk1("t8_idle_empty", instr_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
